// File: rtl/flag_pkg.sv
// Shared encodings for the flag unit: ALU flag modes, FLAG bit positions
// and the jump-condition codes consumed downstream of FLAG.
package flag_pkg;

    typedef enum logic [1:0] {
        FM_LOGIC = 2'b00,
        FM_ADD   = 2'b01,
        FM_SUB   = 2'b10,
        FM_SHIFT = 2'b11
    } flag_mode_e;

    localparam int FLG_S = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [2:0] {
        JC_EQ = 3'b000,
        JC_LT = 3'b001,
        JC_LE = 3'b010,
        JC_NE = 3'b011
    } jump_cond_e;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/flag_stack.sv
// LIFO of saved FLAG values: storage, pointer, full/empty and sticky misuse
// detection. Only instantiated by flag_unit when FLAG_STACK_EN is defined.
module flag_stack
    import flag_pkg::*;
#(
    parameter int STK_DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  logic   err_clr,
    input  flags_t push_data,
    output flags_t top_data,
    output logic   pop_ok,
    output logic   full,
    output logic   empty,
    output logic   err
);

    localparam int AW = $clog2(STK_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] ptr_q, ptr_d;
    flags_t        mem_q [STK_DEPTH];
    flags_t        mem_d [STK_DEPTH];
    logic          err_q, err_d;
    logic          push_ok;
    logic          misuse;
    logic [AW-1:0] wr_idx, rd_idx;

    assign full     = (ptr_q == PW'(STK_DEPTH));
    assign empty    = (ptr_q == '0);
    assign push_ok  = push & ~pop & ~full;
    assign pop_ok   = pop & ~push & ~empty;
    assign misuse   = (push & pop) | (push & full) | (pop & empty);
    assign wr_idx   = AW'(ptr_q);
    assign rd_idx   = AW'(ptr_q - 1'b1);
    assign top_data = mem_q[rd_idx];
    assign err      = err_q;

    // NOTE: every always_comb output is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        err_d = err_q;
        if (push_ok) begin
            mem_d[wr_idx] = push_data;
            ptr_d         = ptr_q + 1'b1;
        end else if (pop_ok) begin
            ptr_d = ptr_q - 1'b1;
        end
        // A fresh misuse outranks a clear in the same cycle.
        if (misuse) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // NOTE: the storage is reset along with the pointer because reset must
    // leave every entry at zero; this is why it is flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < STK_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/flag_unit.sv
// Status-flag register {S,Z,C,V} fed from the ALU, with an optional
// save/restore stack enabled by defining FLAG_STACK_EN.
module flag_unit
    import flag_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int STK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_we,
    input  logic [1:0]        flag_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              sh_c,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    output logic [3:0]        FLAG,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_err
);

    flags_t flag_q, flag_d;
    flags_t alu_flags;
    logic   a_msb, b_msb, r_msb;

    assign a_msb = a[DATA_W-1];
    assign b_msb = b[DATA_W-1];
    assign r_msb = alu_result[DATA_W-1];

    always_comb begin
        alu_flags        = '0;
        alu_flags[FLG_S] = r_msb;
        alu_flags[FLG_Z] = (alu_result == '0);
        case (flag_mode)
            FM_ADD: begin
                // a+b carries out exactly when b exceeds the headroom ~a.
                alu_flags[FLG_C] = (b > ~a);
                alu_flags[FLG_V] = (a_msb == b_msb) && (r_msb != a_msb);
            end
            FM_SUB: begin
                alu_flags[FLG_C] = (a < b);
                alu_flags[FLG_V] = (a_msb != b_msb) && (r_msb != a_msb);
            end
            FM_SHIFT: alu_flags[FLG_C] = sh_c;
            default:  ;
        endcase
    end

`ifdef FLAG_STACK_EN
    flags_t stk_top;
    logic   stk_pop_ok;

    flag_stack #(
        .STK_DEPTH(STK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .err_clr  (err_clr),
        .push_data(flag_q),
        .top_data (stk_top),
        .pop_ok   (stk_pop_ok),
        .full     (stk_full),
        .empty    (stk_empty),
        .err      (stk_err)
    );

    // A lone pop owns FLAG this cycle: it restores or, if empty, holds.
    always_comb begin
        flag_d = flag_q;
        if (pop && !push) begin
            if (stk_pop_ok) begin
                flag_d = stk_top;
            end
        end else if (flag_we) begin
            flag_d = alu_flags;
        end
    end
`else
    logic unused_stk_inputs;

    assign unused_stk_inputs = ^{push, pop, err_clr};
    assign stk_full          = 1'b0;
    assign stk_empty         = 1'b1;
    assign stk_err           = 1'b0;

    always_comb begin
        flag_d = flag_q;
        if (flag_we) begin
            flag_d = alu_flags;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign FLAG = flag_q;

endmodule

// File: tb/tb_flag_unit.sv
// Randomised scoreboard bench for flag_unit: the driver pushes expected state
// from a queue-based reference model, an independent monitor compares.
module tb_flag_unit;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
`ifdef FLAG_STACK_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flag_we = 1'b0;
    logic [1:0]    flag_mode = 2'b00;
    logic [DW-1:0] a = '0, b = '0, alu_result = '0;
    logic          sh_c = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [3:0]    FLAG;
    logic          stk_full, stk_empty, stk_err;

    flag_unit #(.DATA_W(DW), .STK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_mode(flag_mode),
        .a(a), .b(b), .alu_result(alu_result), .sh_c(sh_c),
        .push(push), .pop(pop), .err_clr(err_clr), .FLAG(FLAG),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flag;
        bit         full;
        bit         empty;
        bit         err;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] m_flag;
    logic [3:0] m_stk[$];
    bit         m_err;
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference flags from integer arithmetic on the operands.
    function automatic logic [3:0] ref_flags(input logic [1:0] mode, input logic [DW-1:0] ia,
                                             input logic [DW-1:0] ib, input logic [DW-1:0] res,
                                             input bit shc);
        int  ua = ia;
        int  ub = ib;
        int  sa = $signed(ia);
        int  sb = $signed(ib);
        bit  c = 1'b0;
        bit  v = 1'b0;
        logic [DW-1:0] r = res;
        case (mode)
            2'b01: begin
                c = (ua + ub) > 65535;
                v = (sa + sb > 32767) || (sa + sb < -32768);
            end
            2'b10: begin
                c = ua < ub;
                v = (sa - sb > 32767) || (sa - sb < -32768);
            end
            2'b11: c = shc;
            default: ;
        endcase
        return {r[DW-1], (res == 0), c, v};
    endfunction

    task automatic model_reset();
        m_flag = '0;
        m_stk.delete();
        m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic step(input bit we, input logic [1:0] mode, input logic [DW-1:0] ia,
                        input logic [DW-1:0] ib, input logic [DW-1:0] res, input bit shc,
                        input bit ps, input bit pp, input bit ec);
        logic [3:0] nf;
        bit         err_now;
        exp_t       e;
        @(negedge clk);
        flag_we = we; flag_mode = mode; a = ia; b = ib; alu_result = res;
        sh_c = shc; push = ps; pop = pp; err_clr = ec;
        nf = ref_flags(mode, ia, ib, res, shc);
        err_now = 1'b0;
        if (STK_EN) begin
            if (ps && pp) begin
                err_now = 1'b1;
                if (we) m_flag = nf;
            end else if (pp) begin
                if (m_stk.size() == 0) err_now = 1'b1;
                else m_flag = m_stk.pop_back();
            end else if (ps) begin
                if (m_stk.size() == DEPTH) err_now = 1'b1;
                else m_stk.push_back(m_flag);
                if (we) m_flag = nf;
            end else if (we) begin
                m_flag = nf;
            end
            if (err_now) m_err = 1'b1;
            else if (ec) m_err = 1'b0;
        end else if (we) begin
            m_flag = nf;
        end
        e.flag  = m_flag;
        e.full  = STK_EN && (m_stk.size() == DEPTH);
        e.empty = !STK_EN || (m_stk.size() == 0);
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flag_after_edge(input string name, input logic [3:0] req);
        @(posedge clk);
        #2;
        check(name, FLAG, req);
    endtask

    // Monitor: one expected entry per clock edge, compared just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_flag", FLAG, e.flag);
                check("sb_full", stk_full, e.full);
                check("sb_empty", stk_empty, e.empty);
                check("sb_err", stk_err, e.err);
            end
        end
    end

    initial begin
        logic [1:0]    rm;
        logic [DW-1:0] ra, rb, rr;
        model_reset();
        #1;
        check("reset_flag", FLAG, 4'b0000);
        check("reset_empty", stk_empty, 1'b1);
        check("reset_full", stk_full, 1'b0);
        check("reset_err", stk_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed overflow on add, borrow on sub, zero on equal sub.
        step(1, 2'b01, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 0, 0);
        flag_after_edge("add_ovf", 4'b1001);
        step(1, 2'b10, 16'h0003, 16'h0005, 16'hFFFE, 0, 0, 0, 0);
        flag_after_edge("sub_borrow", 4'b1010);
        step(1, 2'b10, 16'h0005, 16'h0005, 16'h0000, 0, 0, 0, 0);
        flag_after_edge("sub_zero", 4'b0100);

        // Fill with 1,2,4,8, overflow once, drain past empty, clear error.
        step(1, 2'b10, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 0);
        step(1, 2'b11, 16'h0000, 16'h0000, 16'h0001, 1, 1, 0, 0);
        step(1, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0);
        step(1, 2'b00, 16'h0000, 16'h0000, 16'h8000, 0, 1, 0, 0);
        step(0, 2'b00, '0, '0, '0, 0, 1, 0, 0);
        step(0, 2'b00, '0, '0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 2'b00, '0, '0, '0, 0, 0, 1, 0);
        step(0, 2'b00, '0, '0, '0, 0, 0, 0, 1);

        // Pop beats flag_we; push with flag_we stacks the old value.
        step(1, 2'b00, '0, '0, 16'h0000, 0, 0, 0, 0);
        step(0, 2'b00, '0, '0, '0, 0, 1, 0, 0);
        step(1, 2'b00, '0, '0, 16'h8000, 0, 0, 1, 0);
        step(1, 2'b00, '0, '0, 16'h8000, 0, 1, 0, 0);
        step(1, 2'b00, '0, '0, 16'h0000, 0, 1, 1, 0);
        step(0, 2'b00, '0, '0, '0, 0, 0, 0, 1);
        step(0, 2'b00, '0, '0, '0, 0, 1, 1, 1);
        idle();

        for (int i = 0; i < 400; i++) begin
            rm = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (rm == 2'b01) rr = ra + rb;
            else if (rm == 2'b10) rr = ra - rb;
            else rr = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                ra = 16'h8000; rb = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
                rr = (rm == 2'b10) ? ra - rb : ra + rb;
            end
            step(1'($urandom_range(0, 1)), rm, ra, rb, rr, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0);
        end

        // Asynchronous reset between edges, with a push in flight.
        step(1, 2'b00, '0, '0, 16'h8000, 0, 1, 0, 1);
        step(0, 2'b00, '0, '0, '0, 0, 1, 0, 0);
        @(negedge clk);
        push = 1'b1; flag_we = 1'b1; alu_result = 16'h0000;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_flag", FLAG, 4'b0000);
        check("async_rst_empty", stk_empty, 1'b1);
        check("async_rst_full", stk_full, 1'b0);
        check("async_rst_err", stk_err, 1'b0);
        push = 1'b0; flag_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) step(0, 2'b00, '0, '0, '0, 0, 0, 1, 0);
        idle();

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter DATA_W, default 16: width of ALU operands and result.
REQ-002 Parameter STK_DEPTH, default 4: number of flag-stack entries (power of two, 2..16).
REQ-003 clk  in  1: single clock; all state updates on rising edge.
REQ-004 rst_n  in  1: asynchronous, active-low reset.
REQ-005 flag_we  in  1: update FLAG from the current ALU operation.
REQ-006 flag_mode  in  2: 00 logic, 01 add, 10 sub, 11 shift.
REQ-007 a, b  in  DATA_W each: ALU operands.
REQ-008 alu_result  in  DATA_W: ALU result for the same operation.
REQ-009 sh_c  in  1: bit shifted out, used in shift mode only.
REQ-010 push, pop  in  1 each: save FLAG to stack / restore FLAG from stack.
REQ-011 err_clr  in  1: clear stk_err.
REQ-012 FLAG  out  4: registered {S,Z,C,V}, bit 3 = S, bit 0 = V; this is the FLAG input of the jump-condition evaluator.
REQ-013 stk_full, stk_empty, stk_err  out  1 each: stack status; stk_err is a sticky misuse flag.

Function
REQ-014 S SHALL be alu_result[DATA_W-1] and Z SHALL be (alu_result == 0) in every mode.
REQ-015 Add: C = carry out of a+b (DATA_W+1-bit sum); V = (a_msb == b_msb) && (res_msb != a_msb).
REQ-016 Sub: C = borrow, i.e. 1 when a < b unsigned; V = (a_msb != b_msb) && (res_msb != a_msb).
REQ-017 Logic: C = 0, V = 0. Shift: C = sh_c, V = 0.
REQ-018 FLAG SHALL change only on a clock edge; new flags are visible on the cycle after flag_we (1-cycle latency); FLAG holds when no update source is active.
REQ-019 Push SHALL store the pre-edge FLAG value at the stack pointer and increment the pointer.
REQ-020 Pop SHALL decrement the pointer and load FLAG from the new top entry, LIFO order.
REQ-021 Pop and flag_we in the same cycle: the pop wins and the flag_we update is discarded.
REQ-022 Push and flag_we in the same cycle: the old FLAG is pushed and FLAG takes the new value.
REQ-023 Push and pop in the same cycle: neither executes and stk_err sets; a flag_we update in that cycle still applies.
REQ-024 Push when full: the push is dropped, contents are unchanged and stk_err sets.
REQ-025 Pop when empty: FLAG is unchanged and stk_err sets.
REQ-026 stk_full = (pointer == STK_DEPTH); stk_empty = (pointer == 0); both are registered-state derived with no combinational path from push or pop.
REQ-027 stk_err SHALL clear on err_clr; a new error in the same cycle as err_clr SHALL win (stays 1).

Reset
REQ-028 On rst_n low, immediately: FLAG = 4'b0000, pointer = 0, all stack entries = 0, stk_empty = 1, stk_full = 0, stk_err = 0.
REQ-029 Reset asserted mid-operation SHALL abort any push, pop or update in progress with no partial state retained.

Configuration
REQ-030 Macro FLAG_STACK_EN defined: stack logic and storage SHALL be present, per REQ-019..027.
REQ-031 Macro FLAG_STACK_EN undefined:
- no stack storage SHALL be built;
- push, pop and err_clr SHALL be ignored;
- stk_empty SHALL be tied 1, stk_full 0 and stk_err 0;
- flag_we SHALL be the only FLAG update source.

Structure
REQ-032 Shared package flag_pkg SHALL hold:
- flag_mode encodings (FM_LOGIC, FM_ADD, FM_SUB, FM_SHIFT);
- flag bit index constants (FLG_S = 3, FLG_Z = 2, FLG_C = 1, FLG_V = 0);
- jump cond encodings 000 EQ, 001 LT, 010 LE, 011 NE.
REQ-033 The LIFO SHALL be a sub-module flag_stack (storage, pointer, full/empty, error detect), instantiated only under FLAG_STACK_EN.

Verification (DATA_W = 16, STK_DEPTH = 4)
REQ-034 add, a=7FFF, b=0001, res=8000, flag_we -> FLAG = 1001 next cycle.
REQ-035 sub, a=0003, b=0005, res=FFFE -> FLAG = 1010; then sub a=0005, b=0005, res=0000 -> FLAG = 0100.
REQ-036 Push FLAG values 1,2,4,8 -> stk_full = 1; 5th push -> stk_err = 1 and contents unchanged; 4 pops -> FLAG = 8,4,2,1; 5th pop -> FLAG stays 1, stk_err stays 1.
REQ-037 FLAG = 0100 pushed; next cycle pop with flag_we (logic, res=8000) -> FLAG = 0100; push with flag_we in one cycle -> old value stacked, new value in FLAG.
REQ-038 Push and pop in one cycle with flag_we (logic, res=0000) -> pointer unchanged, stk_err = 1, FLAG = 0100; err_clr -> stk_err = 0.
REQ-039 rst_n low after 2 pushes, between clock edges -> FLAG = 0, stk_empty = 1, stk_err = 0 without waiting for a clock edge.
